// File: rtl/lateral_inhibit.sv
// lateral_inhibit: winner-take-all arbiter that picks the highest signed potential among requesting neurons.
// Optional feature macro LI_COLLECT_TIMEOUT_EN: COLLECT also ends after COLLECT_WIN cycles with a partial mask.
module lateral_inhibit #(
  parameter int                  N           = 8,
  parameter int                  W           = 24,
  parameter logic signed [W-1:0] TH          = 24'sd15018,
  parameter int                  COLLECT_WIN = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_core_img,
  input  logic [N-1:0]   start_li,
  input  logic [N*W-1:0] potential_bus,
  output logic [N-1:0]   valid_li,
  output logic [N-1:0]   won_lost,
  output logic           li
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (COLLECT_WIN > 1) ? $clog2(COLLECT_WIN) : 1;
`ifdef LI_COLLECT_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMPARE = 2'd2,
    RESPOND = 2'd3
  } state_t;

  // Strict greater-than keeps the earlier (lower) index on ties.
  function automatic logic beats(input logic signed [W-1:0] cand,
                                 input logic signed [W-1:0] best,
                                 input logic                have_best);
    return (!have_best) || (cand > best);
  endfunction

  state_t                state_r, state_s;
  logic [N-1:0]          req_mask_r;
  logic [IW-1:0]         idx_r;
  logic signed [W-1:0]   best_r;
  logic [IW-1:0]         best_idx_r;
  logic                  found_r;
  logic [CW-1:0]         cnt_r;
  logic [N-1:0]          valid_li_r;
  logic [N-1:0]          won_lost_r;
  logic                  li_r;

  logic signed [W-1:0]   pot_s;
  logic                  take_s;
  logic signed [W-1:0]   new_best_s;
  logic [IW-1:0]         new_idx_s;
  logic                  new_found_s;
  logic                  eligible_s;
  logic                  last_s;
  logic                  full_s;
  logic                  timeout_s;

  assign pot_s = potential_bus[32'(idx_r)*W +: W];

  // Scan datapath: fold the current index into the running best.
  always_comb begin
    take_s      = 1'b0;
    new_best_s  = best_r;
    new_idx_s   = best_idx_r;
    new_found_s = found_r;
    take_s      = req_mask_r[idx_r] && beats(pot_s, best_r, found_r);
    if (take_s) begin
      new_best_s = pot_s;
      new_idx_s  = idx_r;
    end else begin
      new_best_s = best_r;
      new_idx_s  = best_idx_r;
    end
    new_found_s = found_r | take_s;
    eligible_s  = new_found_s && (new_best_s >= TH);
    last_s      = (idx_r == IW'(N-1));
    full_s      = &req_mask_r;
    timeout_s   = TIMEOUT_EN && (cnt_r == CW'(COLLECT_WIN-1));
  end

  // Next-state logic; a new image overrides everything.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (|start_li) state_s = COLLECT;
        else           state_s = IDLE;
      end
      COLLECT: begin
        if (full_s || timeout_s) state_s = COMPARE;
        else                     state_s = COLLECT;
      end
      COMPARE: begin
        if (last_s) state_s = RESPOND;
        else        state_s = COMPARE;
      end
      RESPOND: state_s = IDLE;
      default: state_s = IDLE;
    endcase
    if (start_core_img) state_s = IDLE;
    else                state_s = state_s;
  end

  // State, request mask, scan registers and registered responses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      req_mask_r <= '0;
      idx_r      <= '0;
      best_r     <= '0;
      best_idx_r <= '0;
      found_r    <= 1'b0;
      cnt_r      <= '0;
      valid_li_r <= '0;
      won_lost_r <= '0;
      li_r       <= 1'b0;
    end else if (start_core_img) begin
      state_r    <= IDLE;
      req_mask_r <= '0;
      idx_r      <= '0;
      best_r     <= '0;
      best_idx_r <= '0;
      found_r    <= 1'b0;
      cnt_r      <= '0;
      valid_li_r <= '0;
      won_lost_r <= '0;
      li_r       <= 1'b0;
    end else begin
      state_r    <= state_s;
      valid_li_r <= '0;
      won_lost_r <= '0;
      case (state_r)
        IDLE: begin
          req_mask_r <= start_li;
          idx_r      <= '0;
          best_r     <= '0;
          best_idx_r <= '0;
          found_r    <= 1'b0;
          cnt_r      <= '0;
        end
        COLLECT: begin
          req_mask_r <= req_mask_r | start_li;
          if (cnt_r != CW'(COLLECT_WIN-1)) cnt_r <= cnt_r + CW'(1);
        end
        COMPARE: begin
          best_r     <= new_best_s;
          best_idx_r <= new_idx_s;
          found_r    <= new_found_s;
          if (last_s) begin
            idx_r      <= '0;
            valid_li_r <= req_mask_r;
            won_lost_r <= eligible_s ? (N'(1) << new_idx_s) : '0;
            if (eligible_s) li_r <= 1'b1;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        RESPOND: begin
          req_mask_r <= '0;
          idx_r      <= '0;
          cnt_r      <= '0;
        end
        default: begin
          req_mask_r <= '0;
          idx_r      <= '0;
        end
      endcase
    end
  end

  assign valid_li = valid_li_r;
  assign won_lost = won_lost_r;
  assign li       = li_r;

endmodule

// File: tb/tb_lateral_inhibit.sv
// Self-checking bench for lateral_inhibit: two instances (default threshold and TH=-10) share stimulus.
// Table vectors, hand sequences for abort/reset corners, then randomized arbitrations against a reference model.
module tb_lateral_inhibit;
  localparam int N = 8;
  localparam int W = 24;
  localparam int TH_A = 15018;
  localparam int TH_B = -10;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start_core_img = 1'b0;
  logic [N-1:0]   start_li = '0;
  logic [N*W-1:0] potential_bus = '0;
  logic [N-1:0]   valid_a, won_a, valid_b, won_b;
  logic           li_a, li_b;

  int checks = 0;
  int errors = 0;

  lateral_inhibit #(.N(N), .W(W), .TH(24'sd15018), .COLLECT_WIN(4)) dut_a (
    .clk(clk), .rst(rst), .start_core_img(start_core_img), .start_li(start_li),
    .potential_bus(potential_bus), .valid_li(valid_a), .won_lost(won_a), .li(li_a));

  lateral_inhibit #(.N(N), .W(W), .TH(-24'sd10), .COLLECT_WIN(4)) dut_b (
    .clk(clk), .rst(rst), .start_core_img(start_core_img), .start_li(start_li),
    .potential_bus(potential_bus), .valid_li(valid_b), .won_lost(won_b), .li(li_b));

  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] bus;
    logic [N-1:0]   exp_a;
    logic [N-1:0]   exp_b;
    bit             split;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pk(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
    return {W'(a7), W'(a6), W'(a5), W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  // Reference: highest signed potential among requesters, lowest index on ties, gated by threshold.
  function automatic logic [N-1:0] ref_win(input logic [N*W-1:0] bus, input logic [N-1:0] m, input int th);
    int best;
    int bi;
    bit have;
    logic signed [W-1:0] p;
    have = 1'b0;
    best = 0;
    bi = 0;
    for (int i = 0; i < N; i++) begin
      p = bus[i*W +: W];
      if (m[i] && (!have || int'(p) > best)) begin
        have = 1'b1;
        best = int'(p);
        bi = i;
      end
    end
    if (have && best >= th) return N'(1) << bi;
    return '0;
  endfunction

  task automatic drive(input logic [N-1:0] m);
    start_li = m;
    @(negedge clk);
    start_li = '0;
  endtask

  task automatic core_img();
    start_core_img = 1'b1;
    @(negedge clk);
    start_core_img = 1'b0;
  endtask

  task automatic idle_check(input string tag, input int cyc);
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      chk({tag, "_no_valid"}, 32'({valid_a, valid_b}), 32'h0);
    end
  endtask

  task automatic wait_resp(input string tag, input logic [N-1:0] m, input logic [N-1:0] wa,
                           input logic [N-1:0] wb, input logic la, input logic lb,
                           input int lat, input bit inj);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (n < 60 && !got) begin
      @(negedge clk);
      n++;
      if (inj && n == 3) start_li = N'($urandom_range(1, 255));
      else if (inj && n == 4) start_li = '0;
      if (valid_a != '0 || valid_b != '0) got = 1'b1;
      else chk({tag, "_won_idle"}, 32'({won_a, won_b}), 32'h0);
    end
    chk({tag, "_resp_seen"}, 32'(got), 32'h1);
    if (got) begin
      chk({tag, "_valid_a"}, 32'(valid_a), 32'(m));
      chk({tag, "_valid_b"}, 32'(valid_b), 32'(m));
      chk({tag, "_won_a"}, 32'(won_a), 32'(wa));
      chk({tag, "_won_b"}, 32'(won_b), 32'(wb));
      chk({tag, "_li_a"}, 32'(li_a), 32'(la));
      chk({tag, "_li_b"}, 32'(li_b), 32'(lb));
      if (lat > 0) chk({tag, "_latency"}, 32'(n), 32'(lat));
      if (inj) start_li = N'($urandom_range(1, 255));
      @(negedge clk);
      start_li = '0;
      chk({tag, "_pulse_end"}, 32'({valid_a, valid_b, won_a, won_b}), 32'h0);
    end
  endtask

  initial begin
    logic [N*W-1:0] bus;
    logic [N-1:0]   wa, wb, acc, m;
    logic           li_ma, li_mb;
    int             k, v;

    tbl[0] = '{pk(100, 200, 16000, 300, 16000, 5, 0, -1), 8'h04, 8'h04, 1'b0};
    tbl[1] = '{pk(100, 100, 100, 15017, 100, 100, 100, 100), 8'h00, 8'h08, 1'b1};
    tbl[2] = '{pk(-500, -500, -500, -500, -500, -500, -500, -2), 8'h00, 8'h80, 1'b0};
    tbl[3] = '{pk(20000, 20000, 20000, 20000, 20000, 20000, 20000, 20000), 8'h01, 8'h01, 1'b1};
    tbl[4] = '{pk(15999, 15999, 15999, 15999, 15999, 15999, 15999, 16000), 8'h80, 8'h80, 1'b0};
    tbl[5] = '{pk(0, 1, 2, 3, 4, 15018, 6, 7), 8'h20, 8'h20, 1'b1};
    tbl[6] = '{pk(-500, -500, -500, -500, -500, -500, -500, -500), 8'h00, 8'h00, 1'b0};
    tbl[7] = '{pk(-11, -10, -11, -11, -11, -11, -11, -11), 8'h00, 8'h02, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({valid_a, won_a, li_a, valid_b, won_b, li_b}), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      potential_bus = tbl[i].bus;
      core_img();
      chk($sformatf("vec%0d_li_clear", i), 32'({li_a, li_b}), 32'h0);
      if (tbl[i].split) begin
        drive(8'h0F);
        drive(8'hF0);
      end else begin
        drive(8'hFF);
      end
      wait_resp($sformatf("vec%0d", i), 8'hFF, tbl[i].exp_a, tbl[i].exp_b,
                |tbl[i].exp_a, |tbl[i].exp_b, N + 1, bit'(i % 2));
      idle_check($sformatf("vec%0d_after", i), 3);
    end

    // New image in the same cycle as a request wins; nothing is arbitrated.
    potential_bus = tbl[0].bus;
    start_core_img = 1'b1;
    start_li = 8'hFF;
    @(negedge clk);
    start_core_img = 1'b0;
    start_li = '0;
    idle_check("img_priority", 15);

    // Abort in COMPARE cycle 3 after li was already set.
    drive(8'hFF);
    wait_resp("pre_abort", 8'hFF, 8'h04, 8'h04, 1'b1, 1'b1, N + 1, 1'b0);
    drive(8'hFF);
    repeat (3) @(negedge clk);
    start_core_img = 1'b1;
    @(negedge clk);
    start_core_img = 1'b0;
    chk("abort_li", 32'({li_a, li_b}), 32'h0);
    idle_check("abort", 15);
    drive(8'hFF);
    wait_resp("post_abort", 8'hFF, 8'h04, 8'h04, 1'b1, 1'b1, N + 1, 1'b0);

    // Reset during the last COMPARE cycle suppresses the response.
    drive(8'hFF);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst_mid_outputs", 32'({valid_a, won_a, li_a, valid_b, won_b, li_b}), 32'h0);
    idle_check("rst_mid", 15);
    drive(8'hFF);
    wait_resp("post_rst", 8'hFF, 8'h04, 8'h04, 1'b1, 1'b1, N + 1, 1'b0);

    // Partial request mask.
    potential_bus = pk(0, 0, 0, 0, 20000, 0, 0, 0);
    core_img();
    drive(8'h11);
`ifdef LI_COLLECT_TIMEOUT_EN
    wait_resp("timeout", 8'h11, 8'h10, 8'h10, 1'b1, 1'b1, 0, 1'b0);
`else
    idle_check("partial_wait", 20);
    drive(8'hEE);
    wait_resp("partial_done", 8'hFF, 8'h10, 8'h10, 1'b1, 1'b1, N + 1, 1'b0);
`endif

    // Randomized arbitrations; li is sticky across them.
    core_img();
    li_ma = 1'b0;
    li_mb = 1'b0;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++) begin
        v = int'($urandom_range(0, 40000)) - 20000;
        bus[i*W +: W] = W'(v);
      end
      if (it % 4 == 0) begin
        k = int'($urandom_range(0, N - 1));
        v = int'($urandom_range(0, N - 1));
        bus[v*W +: W] = bus[k*W +: W];
      end
      if (it % 5 == 0) begin
        k = int'($urandom_range(0, N - 1));
        bus[k*W +: W] = W'(15017 + int'($urandom_range(0, 2)));
      end
      potential_bus = bus;
      wa = ref_win(bus, 8'hFF, TH_A);
      wb = ref_win(bus, 8'hFF, TH_B);
      li_ma = li_ma | (|wa);
      li_mb = li_mb | (|wb);
      acc = '0;
      k = int'($urandom_range(1, 3));
      for (int j = 0; j < k - 1; j++) begin
        m = N'($urandom) & 8'h7F;
        drive(m);
        acc = acc | m;
      end
      drive(~acc);
      wait_resp($sformatf("rand%0d", it), 8'hFF, wa, wb, li_ma, li_mb, N + 1, bit'(it % 2));
      idle_check($sformatf("rand%0d_after", it), 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
